// File: rtl/lcd_ctrl_if.sv
// LCD panel pin bundle: 8-bit data bus, register select, read/write, enable and power.
interface lcd_ctrl_if;
  logic [7:0] data;
  logic       rs;
  logic       rw;
  logic       en;
  logic       on;

  modport master (output data, rs, rw, en, on);
  modport slave  (input  data, rs, rw, en, on);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style write sequencer driven by the core's LCD register: toggle-strobed
// requests become timed RS/data setup, E pulse, hold and execution wait.
module lcd_ctrl #(
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_PULSE = 12,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned T_EXEC  = 2500,
  parameter int unsigned T_LONG  = 82000,
  parameter int unsigned T_INIT  = 2000000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [31:0]       io_lcd_i,
  lcd_ctrl_if.master        lcd,
  output logic              busy_o,
  output logic              overrun_o
);

  localparam int unsigned T_M0  = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
  localparam int unsigned T_M1  = (T_M0 > T_HOLD) ? T_M0 : T_HOLD;
  localparam int unsigned T_M2  = (T_M1 > T_EXEC) ? T_M1 : T_EXEC;
  localparam int unsigned T_M3  = (T_M2 > T_LONG) ? T_M2 : T_LONG;
  localparam int unsigned T_MAX = (T_M3 > T_INIT) ? T_M3 : T_INIT;
  localparam int unsigned CW    = $clog2(T_MAX + 1);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_EXEC
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            tog_q;
  logic            pend_v_q, pend_v_d;
  logic            pend_rs_q, pend_rs_d;
  logic [7:0]      pend_data_q, pend_data_d;
  logic            rs_q, rs_d;
  logic [7:0]      data_q, data_d;
  logic            en_q;
  logic            on_q;
  logic            busy_q;
  logic            ovr_q, ovr_d;

  logic            req_c;
  logic            cnt_zero_c;
  logic            pend_take_c;
  logic            accept_direct_c;
  logic            is_long_c;
  logic            unused_c;

  assign req_c           = io_lcd_i[10] ^ tog_q;
  assign cnt_zero_c      = (cnt_q == '0);
  assign accept_direct_c = (state_q == S_IDLE) && !pend_v_q;
  assign is_long_c       = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
  assign unused_c        = ^{io_lcd_i[30:11], io_lcd_i[8]};

  // Next-state, counter, output-register and pending-buffer logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_zero_c ? cnt_q : cnt_q - CW'(1);
    rs_d        = rs_q;
    data_d      = data_q;
    pend_v_d    = pend_v_q;
    pend_rs_d   = pend_rs_q;
    pend_data_d = pend_data_q;
    ovr_d       = ovr_q;
    pend_take_c = 1'b0;

    case (state_q)
      S_INIT: begin
        if (cnt_zero_c) begin
          if (pend_v_q) begin
            state_d     = S_SETUP;
            cnt_d       = CW'(T_SETUP - 1);
            rs_d        = pend_rs_q;
            data_d      = pend_data_q;
            pend_take_c = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        // A pending entry can only be left here if it arrived on an exit cycle
        if (pend_v_q) begin
          state_d     = S_SETUP;
          cnt_d       = CW'(T_SETUP - 1);
          rs_d        = pend_rs_q;
          data_d      = pend_data_q;
          pend_take_c = 1'b1;
        end else if (req_c) begin
          state_d = S_SETUP;
          cnt_d   = CW'(T_SETUP - 1);
          rs_d    = io_lcd_i[9];
          data_d  = io_lcd_i[7:0];
        end
      end
      S_SETUP: begin
        if (cnt_zero_c) begin
          state_d = S_PULSE;
          cnt_d   = CW'(T_PULSE - 1);
        end
      end
      S_PULSE: begin
        if (cnt_zero_c) begin
          state_d = S_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end
      end
      S_HOLD: begin
        if (cnt_zero_c) begin
          state_d = S_EXEC;
          cnt_d   = is_long_c ? CW'(T_LONG - 1) : CW'(T_EXEC - 1);
        end
      end
      S_EXEC: begin
        if (cnt_zero_c) begin
          if (pend_v_q) begin
            state_d     = S_SETUP;
            cnt_d       = CW'(T_SETUP - 1);
            rs_d        = pend_rs_q;
            data_d      = pend_data_q;
            pend_take_c = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (pend_take_c) begin
      pend_v_d = 1'b0;
    end

    // A request outside direct IDLE acceptance goes to the buffer; a full buffer drops it
    if (req_c && !accept_direct_c) begin
      if (!pend_v_q || pend_take_c) begin
        pend_v_d    = 1'b1;
        pend_rs_d   = io_lcd_i[9];
        pend_data_d = io_lcd_i[7:0];
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_INIT;
      cnt_q       <= CW'(T_INIT - 1);
      tog_q       <= io_lcd_i[10];
      pend_v_q    <= 1'b0;
      pend_rs_q   <= 1'b0;
      pend_data_q <= 8'h00;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      en_q        <= 1'b0;
      on_q        <= 1'b0;
      busy_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tog_q       <= io_lcd_i[10];
      pend_v_q    <= pend_v_d;
      pend_rs_q   <= pend_rs_d;
      pend_data_q <= pend_data_d;
      rs_q        <= rs_d;
      data_q      <= data_d;
      en_q        <= (state_d == S_PULSE);
      on_q        <= io_lcd_i[31];
      busy_q      <= (state_d != S_IDLE) || pend_v_d;
      ovr_q       <= ovr_d;
    end
  end

  assign lcd.data  = data_q;
  assign lcd.rs    = rs_q;
  assign lcd.rw    = 1'b0;
  assign lcd.en    = en_q;
  assign lcd.on    = on_q;
  assign busy_o    = busy_q;
  assign overrun_o = ovr_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing parameters.
module tb_lcd_ctrl;
  localparam int unsigned TS = 2;
  localparam int unsigned TP = 3;
  localparam int unsigned TH = 2;
  localparam int unsigned TE = 5;
  localparam int unsigned TL = 20;
  localparam int unsigned TI = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] io_lcd;
  logic        busy;
  logic        overrun;
  logic        tog_lvl = 1'b0;

  int total = 0;
  int bad   = 0;

  logic       obs_en   [0:63];
  logic [7:0] obs_data [0:63];
  logic       obs_rs   [0:63];
  logic       obs_busy [0:63];
  logic       obs_ovr  [0:63];

  lcd_ctrl_if lcd_bus ();

  lcd_ctrl #(
    .T_SETUP (TS),
    .T_PULSE (TP),
    .T_HOLD  (TH),
    .T_EXEC  (TE),
    .T_LONG  (TL),
    .T_INIT  (TI)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .io_lcd_i  (io_lcd),
    .lcd       (lcd_bus),
    .busy_o    (busy),
    .overrun_o (overrun)
  );

  always #5 clk = ~clk;

  task automatic flip(input logic rs, input logic [7:0] d);
    tog_lvl = ~tog_lvl;
    io_lcd  = {1'b1, 20'hA5C3E, tog_lvl, rs, 1'b1, d};
  endtask

  // Samples n falling edges; optionally issues one request right after sample inj_at
  task automatic observe(input int n, input int inj_at, input logic inj_rs, input logic [7:0] inj_d);
    obs_en[0] = lcd_bus.en;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      obs_en[i]   = lcd_bus.en;
      obs_data[i] = lcd_bus.data;
      obs_rs[i]   = lcd_bus.rs;
      obs_busy[i] = busy;
      obs_ovr[i]  = overrun;
      if (i == inj_at) flip(inj_rs, inj_d);
    end
  endtask

  function automatic int n_high(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (obs_en[i]) c++;
    return c;
  endfunction

  function automatic int rise_idx(input int k, input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) begin
      if (obs_en[i] && !obs_en[i-1]) begin
        c++;
        if (c == k) return i;
      end
    end
    return -1;
  endfunction

  function automatic int n_rises(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (obs_en[i] && !obs_en[i-1]) c++;
    return c;
  endfunction

  function automatic logic [8:0] rise_word(input int k, input int n);
    int idx = rise_idx(k, n);
    if (idx < 0) return 9'h1FF;
    return {obs_rs[idx], obs_data[idx]};
  endfunction

  function automatic int busy_fall(input int n);
    for (int i = 1; i <= n; i++) if (!obs_busy[i]) return i;
    return -1;
  endfunction

  function automatic int n_ovr(input int n);
    int c = 0;
    for (int i = 1; i <= n; i++) if (obs_ovr[i]) c++;
    return c;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({lcd_bus.data, lcd_bus.rs, lcd_bus.rw, lcd_bus.en, lcd_bus.on, busy, overrun} !== 14'h0) begin
      bad++;
      $display("FAIL reset_outputs: got %h want 0",
               {lcd_bus.data, lcd_bus.rs, lcd_bus.rw, lcd_bus.en, lcd_bus.on, busy, overrun});
    end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({lcd_bus.on, busy, lcd_bus.en, lcd_bus.rw} !== 4'b1100) begin
      bad++;
      $display("FAIL after_reset on/busy/en/rw: got %b want 1100", {lcd_bus.on, busy, lcd_bus.en, lcd_bus.rw});
    end
  endtask

  task automatic test_init_holdoff();
    do_reset();
    @(negedge clk);
    @(negedge clk);
    flip(1'b1, 8'h41);
    observe(25, 0, 1'b0, 8'h00);
    total++;
    if (rise_idx(1, 25) != 10) begin
      bad++;
      $display("FAIL init_first_rise: got %0d want 10", rise_idx(1, 25));
    end
    total++;
    if (n_rises(25) != 1 || n_high(25) != 3) begin
      bad++;
      $display("FAIL init_pulse rises/high: got %0d/%0d want 1/3", n_rises(25), n_high(25));
    end
    total++;
    if (rise_word(1, 25) !== 9'h141) begin
      bad++;
      $display("FAIL init_word: got %h want 141", rise_word(1, 25));
    end
    total++;
    if (busy_fall(25) != 20) begin
      bad++;
      $display("FAIL init_busy_fall: got %0d want 20", busy_fall(25));
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    flip(1'b1, 8'h48);
    observe(20, 0, 1'b0, 8'h00);
    total++;
    if (rise_idx(1, 20) != 3 || n_high(20) != 3 || n_rises(20) != 1) begin
      bad++;
      $display("FAIL single_pulse rise/high/rises: got %0d/%0d/%0d want 3/3/1",
               rise_idx(1, 20), n_high(20), n_rises(20));
    end
    for (int i = 1; i <= 7; i++) begin
      total++;
      if ({obs_rs[i], obs_data[i]} !== 9'h148) begin
        bad++;
        $display("FAIL single_stable[%0d]: got %h want 148", i, {obs_rs[i], obs_data[i]});
      end
    end
    total++;
    if (obs_busy[1] !== 1'b1 || busy_fall(20) != 13) begin
      bad++;
      $display("FAIL single_busy first/fall: got %b/%0d want 1/13", obs_busy[1], busy_fall(20));
    end
  endtask

  task automatic test_long();
    logic [8:0] cmd [0:5];
    int         exp_fall [0:5];
    cmd[0] = 9'h001; exp_fall[0] = 28;
    cmd[1] = 9'h038; exp_fall[1] = 13;
    cmd[2] = 9'h002; exp_fall[2] = 28;
    cmd[3] = 9'h003; exp_fall[3] = 28;
    cmd[4] = 9'h101; exp_fall[4] = 13;
    cmd[5] = 9'h004; exp_fall[5] = 13;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      flip(cmd[k][8], cmd[k][7:0]);
      observe(35, 0, 1'b0, 8'h00);
      total++;
      if (busy_fall(35) != exp_fall[k]) begin
        bad++;
        $display("FAIL long_cmd %h busy_fall: got %0d want %0d", cmd[k], busy_fall(35), exp_fall[k]);
      end
    end
  endtask

  task automatic test_two_toggles();
    do_reset();
    for (int i = 0; i < 12; i++) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL two_idle_busy: got %b want 0", busy);
    end
    flip(1'b1, 8'h30);
    @(negedge clk);
    flip(1'b1, 8'h31);
    observe(40, 0, 1'b0, 8'h00);
    total++;
    if (n_rises(40) != 2 || rise_idx(2, 40) != 14 || busy_fall(40) != 24) begin
      bad++;
      $display("FAIL two_timing rises/rise2/fall: got %0d/%0d/%0d want 2/14/24",
               n_rises(40), rise_idx(2, 40), busy_fall(40));
    end
    total++;
    if (rise_word(1, 40) !== 9'h130 || rise_word(2, 40) !== 9'h131) begin
      bad++;
      $display("FAIL two_words: got %h,%h want 130,131", rise_word(1, 40), rise_word(2, 40));
    end
    total++;
    if (n_ovr(40) != 0) begin
      bad++;
      $display("FAIL two_overrun: got %0d cycles high want 0", n_ovr(40));
    end
  endtask

  task automatic test_refill();
    @(negedge clk);
    flip(1'b1, 8'h20);
    @(negedge clk);
    flip(1'b1, 8'h21);
    observe(45, 11, 1'b1, 8'h22);
    total++;
    if (n_rises(45) != 3 || n_high(45) != 9 || rise_idx(3, 45) != 26) begin
      bad++;
      $display("FAIL refill_pulses rises/high/rise3: got %0d/%0d/%0d want 3/9/26",
               n_rises(45), n_high(45), rise_idx(3, 45));
    end
    total++;
    if (rise_word(1, 45) !== 9'h120 || rise_word(2, 45) !== 9'h121 || rise_word(3, 45) !== 9'h122) begin
      bad++;
      $display("FAIL refill_words: got %h,%h,%h want 120,121,122",
               rise_word(1, 45), rise_word(2, 45), rise_word(3, 45));
    end
    total++;
    if (n_ovr(45) != 0 || busy_fall(45) != 36) begin
      bad++;
      $display("FAIL refill ovr/fall: got %0d/%0d want 0/36", n_ovr(45), busy_fall(45));
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    flip(1'b1, 8'h10);
    @(negedge clk);
    flip(1'b1, 8'h11);
    @(negedge clk);
    total++;
    if (overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_pre_overrun: got %b want 0", overrun);
    end
    flip(1'b1, 8'h12);
    observe(40, 0, 1'b0, 8'h00);
    total++;
    if (obs_ovr[1] !== 1'b1 || n_ovr(40) != 40) begin
      bad++;
      $display("FAIL b2b_overrun first/count: got %b/%0d want 1/40", obs_ovr[1], n_ovr(40));
    end
    total++;
    if (n_rises(40) != 2 || rise_idx(2, 40) != 13 || busy_fall(40) != 23) begin
      bad++;
      $display("FAIL b2b_timing rises/rise2/fall: got %0d/%0d/%0d want 2/13/23",
               n_rises(40), rise_idx(2, 40), busy_fall(40));
    end
    total++;
    if (rise_word(1, 40) !== 9'h110 || rise_word(2, 40) !== 9'h111) begin
      bad++;
      $display("FAIL b2b_words: got %h,%h want 110,111", rise_word(1, 40), rise_word(2, 40));
    end
    @(negedge clk);
    flip(1'b1, 8'h55);
    observe(20, 0, 1'b0, 8'h00);
    total++;
    if (obs_ovr[20] !== 1'b1 || n_rises(20) != 1 || rise_word(1, 20) !== 9'h155) begin
      bad++;
      $display("FAIL b2b_sticky ovr/rises/word: got %b/%0d/%h want 1/1/155",
               obs_ovr[20], n_rises(20), rise_word(1, 20));
    end
  endtask

  task automatic test_reset_mid_pulse();
    int waited = 0;
    @(negedge clk);
    flip(1'b1, 8'h66);
    @(negedge clk);
    flip(1'b1, 8'h67);
    while (lcd_bus.en !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (lcd_bus.en !== 1'b1) begin
      bad++;
      $display("FAIL midpulse_wait_en: got %b want 1", lcd_bus.en);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({lcd_bus.en, busy, overrun, lcd_bus.rs, lcd_bus.data} !== 12'h000) begin
      bad++;
      $display("FAIL midpulse_reset en/busy/ovr/rs/data: got %h want 000",
               {lcd_bus.en, busy, overrun, lcd_bus.rs, lcd_bus.data});
    end
    rst = 1'b0;
    observe(30, 0, 1'b0, 8'h00);
    total++;
    if (n_rises(30) != 0 || busy_fall(30) != 10 || n_ovr(30) != 0) begin
      bad++;
      $display("FAIL midpulse_after rises/fall/ovr: got %0d/%0d/%0d want 0/10/0",
               n_rises(30), busy_fall(30), n_ovr(30));
    end
  endtask

  initial begin
    io_lcd = {1'b1, 20'hA5C3E, 1'b0, 1'b0, 1'b1, 8'h00};
    test_reset();
    test_init_holdoff();
    test_single();
    test_long();
    test_two_toggles();
    test_refill();
    test_back_to_back();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lcd_ctrl.md
Name: lcd_ctrl

Overview:
- Peripheral-side consumer of the core's memory-mapped LCD output register (the 32-bit LCD word the LSU drives).
- Software writes a command/data byte plus a toggle strobe. This block turns each request into a correctly timed HD44780-style parallel write: RS setup, E pulse, hold, then command execution wait.
- Provides a single-entry pending buffer, busy and overrun status, and power-on init delay.
- Sits at top level between the core's LCD register output and the LCD pins.

Parameters:
- T_SETUP, 2, cycles RS/data held stable with E low before E rises (≥1).
- T_PULSE, 12, cycles E held high (≥1).
- T_HOLD, 2, cycles RS/data held after E falls (≥1).
- T_EXEC, 2500, cycles of execution wait after a normal write (≥1).
- T_LONG, 82000, execution wait after clear (0x01) or home (0x02/0x03) commands with RS=0.
- T_INIT, 2000000, cycles after reset before the first transfer may start.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- io_lcd_i  in  32  LCD register from core:
  - [31] display power.
  - [10] request toggle.
  - [9] RS.
  - [7:0] byte.
  - Other bits ignored.
- lcd_data_o  out  8  LCD data bus.
- lcd_rs_o  out  1  register select.
- lcd_rw_o  out  1  read/write; constant 0.
- lcd_en_o  out  1  enable strobe.
- lcd_on_o  out  1  display power, registered io_lcd_i[31].
- busy_o  out  1  high while not IDLE or while pending is valid.
- overrun_o  out  1  sticky; request lost.

Behaviour:
- Reset (rst_i=1 at posedge):
  - State=INIT, counter=T_INIT-1.
  - All outputs 0.
  - Pending empty.
  - tog_q is loaded with io_lcd_i[10]; no request is inferred from reset.
- Request detection:
  - req = io_lcd_i[10] ^ tog_q; tog_q <= io_lcd_i[10] every cycle.
  - On req, {RS, byte} is captured from the same cycle's io_lcd_i.
- lcd_on_o <= io_lcd_i[31] every cycle, in every state.
- Single down-counter cnt; each timed state exits on the cycle cnt==0.
- States and transitions:
  - INIT: counts down. On exit, go to IDLE, or to SETUP if pending is valid.
  - IDLE: on req, load {rs,data} to the output regs and go to SETUP with cnt=T_SETUP-1. Entering SETUP from pending has the same effect and empties pending.
  - SETUP: lcd_en_o=0; lcd_rs_o/lcd_data_o valid. Exit to PULSE, cnt=T_PULSE-1.
  - PULSE: lcd_en_o=1. Exit to HOLD, cnt=T_HOLD-1.
  - HOLD: lcd_en_o=0, data held. Exit to EXEC. cnt=T_LONG-1 if rs==0 and data∈{0x01,0x02,0x03}, else T_EXEC-1.
  - EXEC: on exit, go to SETUP if pending is valid (consume it), else IDLE. Output regs keep their last value.
- lcd_en_o is registered (asserted from the first cycle in PULSE). Exactly T_PULSE high cycles per transfer.
- Latency from toggle edge in IDLE:
  - lcd_en_o rises T_SETUP+1 cycles after the edge cycle.
  - Back in IDLE after T_SETUP+T_PULSE+T_HOLD+T_exec+1 cycles.
- Pending buffer (1 entry):
  - A req in any state other than IDLE fills pending if it is empty.
  - If pending is already full, the new req is dropped, pending keeps the older entry, and overrun_o <= 1.
  - A req arriving in the same cycle pending is consumed (EXEC/INIT exit) is stored into pending (refill); not an overrun.
- overrun_o clears only on reset.
- busy_o = (state!=IDLE) | pending_valid, registered from next-state.
  - In the cycle after a req is accepted in IDLE, busy_o=1.
- Reset mid-transfer: immediate return to INIT. E drops in the next cycle's outputs (reset value 0); pending and overrun are cleared.
- Counter width $clog2(max(all T)+1). Parameters equal to 1 yield single-cycle states.

Test Plan:
- Use T_SETUP=2, T_PULSE=3, T_HOLD=2, T_EXEC=5, T_LONG=20, T_INIT=10 throughout.
- Init hold-off: toggle bit10 with RS=1, data 0x41 at cycle 3 after reset -> no E until INIT ends. The request is then served from pending: data=0x41, rs=1, E high for exactly 3 cycles.
- Single write in IDLE: toggle with RS=1, data 0x48 -> E rises 3 cycles after the edge and is high 3 cycles. Data/rs stable from SETUP through HOLD. busy_o drops 13 cycles after the edge.
- Long command: RS=0, data 0x01 -> EXEC lasts 20 cycles (busy for 2+3+2+20). RS=0, data 0x38 -> EXEC 5 cycles.
- Back-to-back:
  - Three toggles (0x10, 0x11, 0x12) in consecutive cycles during IDLE -> 0x10 sent, 0x11 sent right after EXEC, 0x12 dropped, overrun_o=1 and sticky.
  - Two toggles only -> overrun_o stays 0.
- Refill edge: toggle in the exact cycle pending is consumed at EXEC exit -> the new byte is stored, overrun_o=0, and three E pulses are observed in total.
- Reset mid-PULSE: assert rst_i while lcd_en_o=1 -> next cycle lcd_en_o=0, busy_o=0, overrun_o=0, state INIT. The stale toggle level is not treated as a request.
